// File: rtl/enc_16x4_seq_pkg.sv
// Shared widths and state encoding for the sequential 16-to-4 encoder.
// No logic, so no latency.
// No flow control of its own.
package enc_16x4_seq_pkg;

  localparam int LINES  = 16;
  localparam int CODE_W = 4;
  localparam int CNT_W  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/enc_16x4_pri.sv
// Lowest-set-bit priority encoder with an "exactly one bit set" flag.
// Purely combinational, zero latency.
// No flow control; code is 0 when no bit is set.
module enc_16x4_pri
  import enc_16x4_seq_pkg::*;
(
  input  logic [LINES-1:0]  p,
  output logic [CODE_W-1:0] code,
  output logic              one
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    code = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (p[i]) code = i[CODE_W-1:0];
    end
  end

  // p & (p-1) clears the lowest set bit; zero afterwards means one bit only.
  assign one = (p != '0) && ((p & (p - LINES'(1))) == '0);

endmodule

// File: rtl/enc_16x4_seq.sv
// Captures a 16-bit line word, then emits the index of each set line, lowest first.
// Latency 1 cycle from capture to first code; one code per cycle while out_ready.
// Holds code while out_ready low; in_ready only in IDLE, so new words wait for the scan.
module enc_16x4_seq
  import enc_16x4_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINES-1:0]  D,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  state_t             state, state_n;
  logic [LINES-1:0]   p, p_n;
  logic [CNT_W-1:0]   count_n;
  logic               empty_n;
  logic [CODE_W-1:0]  pri_code;
  logic               pri_one;

  function automatic logic [CNT_W-1:0] popcount(input logic [LINES-1:0] w);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LINES; i++) c = c + CNT_W'(w[i]);
    return c;
  endfunction

  enc_16x4_pri u_pri (
    .p    (p),
    .code (pri_code),
    .one  (pri_one)
  );

  // P is zero outside SCAN, so the code reads 0 whenever nothing is pending.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_SCAN);
  assign out_code  = pri_code;
  assign out_last  = (state == ST_SCAN) && pri_one;

  // Next-state: capture in IDLE, retire the lowest pending line on each handshake.
  always_comb begin
    state_n = state;
    p_n     = p;
    count_n = count;
    empty_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          p_n     = D;
          count_n = popcount(D);
          if (D != '0) state_n = ST_SCAN;
          else         empty_n = 1'b1;
        end
      end
      ST_SCAN: begin
        if (out_ready) begin
          p_n = p & (p - LINES'(1));
          if (pri_one) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, pending word and status registers; reset discards any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      p     <= '0;
      count <= '0;
      empty <= 1'b0;
    end else begin
      state <= state_n;
      p     <= p_n;
      count <= count_n;
      empty <= empty_n;
    end
  end

endmodule

// File: tb/tb_enc_16x4_seq.sv
// Scoreboard bench for enc_16x4_seq: stimulus queues expected codes, monitor checks them.
// Includes a behavioural 4x16 decoder with optional select-MSB stuck-at-0 for loopback.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_enc_16x4_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] D = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  out_code;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        empty;
  logic [4:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       last;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  enc_16x4_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .D         (D),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .empty     (empty),
    .count     (count)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // 4x16 decoder; w_sa0 forces the select MSB (W) to 0.
  function automatic logic [15:0] dec4x16(input logic [3:0] c, input bit w_sa0);
    logic [3:0] s;
    s = c;
    if (w_sa0) s[3] = 1'b0;
    return 16'h0001 << s;
  endfunction

  // Monitor: every presented code must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: code %0d presented, none expected", out_code);
      end else begin
        check("out_code", out_code, exp_q[0].code);
        check("out_last", out_last, exp_q[0].last);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Lowest line first; the highest set line is the last beat.
  task automatic push_word(input logic [15:0] d);
    int hi;
    hi = -1;
    for (int i = 0; i < 16; i++) if (d[i]) hi = i;
    for (int i = 0; i < 16; i++) begin
      if (d[i]) begin
        exp_t e;
        e.code = i[3:0];
        e.last = (i == hi);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic capture(input logic [15:0] d, input int exp_cnt);
    int budget;
    budget = 0;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    D = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    D = 16'hA5A5;
    @(negedge clk);
    check("count", count, exp_cnt);
    check("in_ready_after_capture", in_ready, (d == 16'h0) ? 1 : 0);
  endtask

  task automatic drain(input bit tog);
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 200) begin
      @(posedge clk); #1;
      if (tog) out_ready = ~out_ready;
      budget++;
    end
    check("drain_left", exp_q.size(), 0);
    out_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, 0);
    check("rst_out_last", out_last, 0);
    check("rst_empty", empty, 0);
    check("rst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single line 0: one beat, in_ready back the cycle after the handshake
    push_word(16'h0001);
    capture(16'h0001, 1);
    @(negedge clk);
    check("in_ready_return", in_ready, 1);
    check("q_after_single", exp_q.size(), 0);

    // Sparse word: 0,5,10,15
    push_word(16'h8421);
    capture(16'h8421, 4);
    drain(1'b0);

    // Full word with stalls every other cycle
    push_word(16'hFFFF);
    capture(16'hFFFF, 16);
    drain(1'b1);
    @(negedge clk);
    check("count_hold", count, 16);

    // Back-to-back zero words
    @(posedge clk); #1;
    D = 16'h0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("empty_1", empty, 1);
    check("in_ready_zero", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("empty_2", empty, 1);
    check("count_zero", count, 0);
    @(negedge clk);
    check("empty_3", empty, 0);

    // Reset after two of four beats
    push_word(16'h00F0);
    capture(16'h00F0, 4);
    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 2 && budget < 50) begin
        @(posedge clk); #1;
        budget++;
      end
    end
    check("mid_q", exp_q.size(), 2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_count", count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_out_valid", out_valid, 0);
    push_word(16'h0002);
    capture(16'h0002, 1);
    drain(1'b0);

    // Loopback through the decoder, fault-free then with W stuck-at-0
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 16; c++) begin
        exp_t e;
        e.code = (f == 1 && c >= 8) ? 4'(c - 8) : 4'(c);
        e.last = 1'b1;
        exp_q.push_back(e);
        capture(dec4x16(4'(c), f == 1), 1);
        drain(1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check("final_q", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
